mem_ctrl: RTL and testbench

- Byte-serial memory responder/arbiter between the core's requesters and the single 8-bit RAM/IO port.
- Serves instruction-fetch word reads from IF and 1/2/4-byte loads/stores from the store/load buffer.
- Drives mem_a/mem_dout/mem_wr and assembles mem_din bytes into 32-bit results.
- Sits between IF/SLBuffer and the cpu top-level memory pins.

---
 rtl/mem_ctrl_if.sv | 40 ++++
 rtl/mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Requester and byte-wide memory-port signals of mem_ctrl.
// The slave modport is the controller; the master modport is the IF/LSB requesters plus the RAM/IO side.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic                  if_done_out;
  logic [31:0]           if_data_out;

  logic                  lsb_req_in;
  logic                  lsb_wr_in;
  logic [1:0]            lsb_size_in;
  logic [ADDR_WIDTH-1:0] lsb_addr_in;
  logic [31:0]           lsb_wdata_in;
  logic                  lsb_done_out;
  logic [31:0]           lsb_rdata_out;

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  if_req_in, if_addr_in,
    input  lsb_req_in, lsb_wr_in, lsb_size_in, lsb_addr_in, lsb_wdata_in,
    input  mem_din, io_buffer_full,
    output if_done_out, if_data_out, lsb_done_out, lsb_rdata_out,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req_in, if_addr_in,
    output lsb_req_in, lsb_wr_in, lsb_size_in, lsb_addr_in, lsb_wdata_in,
    output mem_din, io_buffer_full,
    input  if_done_out, if_data_out, lsb_done_out, lsb_rdata_out,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter between instruction fetch and the load/store buffer on one 8-bit RAM/IO port.
// state | meaning
// IDLE  | waiting; accepts one request per edge (LSB_PRIORITY decides ties)
// READ  | presenting A+i and collecting mem_din bytes
// WRITE | issuing store bytes, held back by a full UART buffer on IO addresses
// DONE  | one-cycle done pulse, no acceptance
module mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter bit LSB_PRIORITY = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  output logic        busy_out,
  mem_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
  logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d;
  logic                  src_lsb_q, src_lsb_d, mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [7:0]            mem_dout_q, mem_dout_d;

  logic                  take_lsb, take_if, lsb_io_full, cur_io_full, last_byte;
  logic [2:0]            lsb_n;
  logic [4:0]            sh;
  logic [31:0]           rd_word;

  assign take_lsb    = bus.lsb_req_in && (LSB_PRIORITY || !bus.if_req_in);
  assign take_if     = bus.if_req_in && !take_lsb;
  assign lsb_n       = (bus.lsb_size_in == 2'b00) ? 3'd1 :
                       (bus.lsb_size_in == 2'b01) ? 3'd2 : 3'd4;
  assign lsb_io_full = (bus.lsb_addr_in[17:16] == 2'b11) && bus.io_buffer_full;
  assign cur_io_full = (addr_q[17:16] == 2'b11) && bus.io_buffer_full;
  assign sh          = {cnt_q[1:0], 3'b000};
  assign rd_word     = buf_q | ({24'd0, bus.mem_din} << sh);
  assign last_byte   = (cnt_q + 3'd1) == n_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    src_lsb_d   = src_lsb_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    case (state_q)
      IDLE: begin
        if (!flush_in && take_lsb) begin
          addr_d    = bus.lsb_addr_in;
          n_d       = lsb_n;
          wdata_d   = bus.lsb_wdata_in;
          src_lsb_d = 1'b1;
          buf_d     = '0;
          cnt_d     = '0;
          if (bus.lsb_wr_in) begin
            state_d = WRITE;
            // byte 0 goes out on the accepting edge unless the UART buffer is full
            if (!lsb_io_full) begin
              mem_a_d    = bus.lsb_addr_in;
              mem_dout_d = bus.lsb_wdata_in[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = READ;
            mem_a_d = bus.lsb_addr_in;
          end
        end else if (!flush_in && take_if) begin
          addr_d    = bus.if_addr_in;
          n_d       = 3'd4;
          src_lsb_d = 1'b0;
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = READ;
          mem_a_d   = bus.if_addr_in;
        end
      end
      READ: begin
        if (flush_in) begin
          state_d = IDLE;
          mem_a_d = '0;
          cnt_d   = '0;
        end else begin
          buf_d = rd_word;
          cnt_d = cnt_q + 3'd1;
          if (last_byte) begin
            state_d = DONE;
            mem_a_d = '0;
            if (src_lsb_q) begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = rd_word;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rd_word;
            end
          end else begin
            mem_a_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
          end
        end
      end
      WRITE: begin
        if (cnt_q == n_q) begin
          state_d    = DONE;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end else if (!cur_io_full) begin
          mem_a_d    = addr_q + ADDR_WIDTH'(cnt_q);
          mem_dout_d = wdata_q[sh +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      src_lsb_q   <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      src_lsb_q   <= src_lsb_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign busy_out          = (state_q != IDLE);
  assign bus.mem_a         = mem_a_q;
  assign bus.mem_dout      = mem_dout_q;
  assign bus.mem_wr        = mem_wr_q && rdy_in;
  assign bus.if_done_out   = if_done_q;
  assign bus.if_data_out   = if_data_q;
  assign bus.lsb_done_out  = lsb_done_q;
  assign bus.lsb_rdata_out = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference model queues expected writes and done
// results in service order; a negedge monitor pops and compares whatever the controller presents.
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, busy_out;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .LSB_PRIORITY(1'b1)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .busy_out (busy_out),
    .bus      (bus)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct packed { logic [31:0] a; logic [7:0] d; logic io; } wr_t;
  typedef struct packed { logic st; logic [31:0] d; } lsb_t;

  logic [7:0]  phys    [4096];
  logic [7:0]  ref_mem [4096];
  wr_t         wr_q[$];
  lsb_t        lsb_q[$];
  logic [31:0] if_q[$];
  bit          ord_q[$];   // 1 = LSB done expected next, 0 = IF
  int tests = 0, fails = 0;
  int if_done_cnt = 0, lsb_done_cnt = 0, wr_cnt = 0;
  bit rand_en = 0, rdy_e = 0, io_e = 0, prev_if = 0, prev_lsb = 0;

  assign bus.mem_din = phys[bus.mem_a[11:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Reference: an access of N bytes at A touches (A+i) mod 2^32; loads zero-extend.
  task automatic model_access(input bit is_lsb, input bit wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] ai, data;
    n = !is_lsb ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    data = '0;
    ord_q.push_back(is_lsb);
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (wr) begin
        wr_q.push_back('{a: ai, d: wd[8*i +: 8], io: (a[17:16] == 2'b11)});
        ref_mem[ai[11:0]] = wd[8*i +: 8];
      end else begin
        data = data | (32'(ref_mem[ai[11:0]]) << (8*i));
      end
    end
    if (is_lsb) lsb_q.push_back('{st: wr, d: data});
    else        if_q.push_back(data);
  endtask

  task automatic wait_done(input bit is_lsb, input int start, input string nm);
    bit seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_in); #1;
      if ((is_lsb ? lsb_done_cnt : if_done_cnt) > start) begin seen = 1; break; end
    end
    if (!seen) flag(nm, "no done pulse within 400 cycles");
  endtask

  task automatic lsb_go(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int start;
    @(posedge clk_in); #1;
    start = lsb_done_cnt;
    bus.lsb_wr_in = wr; bus.lsb_size_in = sz; bus.lsb_addr_in = a; bus.lsb_wdata_in = wd;
    bus.lsb_req_in = 1'b1;
    wait_done(1'b1, start, "lsb_timeout");
    bus.lsb_req_in = 1'b0;
  endtask

  task automatic if_go(input logic [31:0] a);
    int start;
    @(posedge clk_in); #1;
    start = if_done_cnt;
    bus.if_addr_in = a;
    bus.if_req_in  = 1'b1;
    wait_done(1'b0, start, "if_timeout");
    bus.if_req_in = 1'b0;
  endtask

  initial begin
    int start, w0, kind;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    lsb_t        le;
    wr_t         we;
    bit          src;
    rst_in = 1'b0; rdy_in = 1'b0; flush_in = 1'b0;
    bus.if_req_in = 1'b0; bus.if_addr_in = '0;
    bus.lsb_req_in = 1'b0; bus.lsb_wr_in = 1'b0; bus.lsb_size_in = '0;
    bus.lsb_addr_in = '0; bus.lsb_wdata_in = '0; bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      phys[i] = 8'($urandom);
      ref_mem[i] = phys[i];
    end

    fork
      forever begin
        @(posedge clk_in);
        rdy_e = rdy_in;
        io_e  = bus.io_buffer_full;
        if (bus.mem_wr) phys[bus.mem_a[11:0]] <= bus.mem_dout;
      end
      forever begin
        @(posedge clk_in); #1;
        if (rand_en) begin
          rdy_in = ($urandom_range(0, 9) != 0);
          bus.io_buffer_full = ($urandom_range(0, 3) == 0);
        end
      end
      forever begin
        @(negedge clk_in);
        if (bus.mem_wr) begin
          wr_cnt++;
          if (wr_q.size() == 0) flag("unexpected_write", $sformatf("addr 0x%0h data 0x%0h", bus.mem_a, bus.mem_dout));
          else begin
            we = wr_q.pop_front();
            chk("wr_addr", 64'(bus.mem_a), 64'(we.a));
            chk("wr_data", 64'(bus.mem_dout), 64'(we.d));
            if (we.io) chk("io_stall", 64'(io_e && rdy_e), 64'd0);
          end
        end
        if (bus.if_done_out && prev_if && rdy_e) flag("if_done_pulse", "done high for more than one cycle");
        if (bus.lsb_done_out && prev_lsb && rdy_e) flag("lsb_done_pulse", "done high for more than one cycle");
        if (bus.if_done_out && !(prev_if && !rdy_e)) begin
          if_done_cnt++;
          if (ord_q.size() == 0 || if_q.size() == 0) flag("if_done_unexpected", "IF done with nothing expected");
          else begin
            src = ord_q.pop_front();
            chk("done_order_if", 64'(src), 64'd0);
            chk("if_data", 64'(bus.if_data_out), 64'(if_q.pop_front()));
          end
        end
        if (bus.lsb_done_out && !(prev_lsb && !rdy_e)) begin
          lsb_done_cnt++;
          if (ord_q.size() == 0 || lsb_q.size() == 0) flag("lsb_done_unexpected", "LSB done with nothing expected");
          else begin
            src = ord_q.pop_front();
            chk("done_order_lsb", 64'(src), 64'd1);
            le = lsb_q.pop_front();
            if (!le.st) chk("lsb_rdata", 64'(bus.lsb_rdata_out), 64'(le.d));
          end
        end
        prev_if  = bus.if_done_out;
        prev_lsb = bus.lsb_done_out;
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // reset overrides a low rdy_in
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_mem_a", 64'(bus.mem_a), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
    chk("rst_if_done", 64'(bus.if_done_out), 64'd0);
    chk("rst_lsb_done", 64'(bus.lsb_done_out), 64'd0);
    chk("rst_if_data", 64'(bus.if_data_out), 64'd0);
    chk("rst_lsb_rdata", 64'(bus.lsb_rdata_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b1; rdy_in = 1'b1;

    // IF word read at 0x100 with exact address timing
    phys[12'h100] = 8'h13; phys[12'h101] = 8'h05; phys[12'h102] = 8'h00; phys[12'h103] = 8'h00;
    ref_mem[12'h100] = 8'h13; ref_mem[12'h101] = 8'h05; ref_mem[12'h102] = 8'h00; ref_mem[12'h103] = 8'h00;
    model_access(1'b0, 1'b0, 2'd0, 32'h100, 32'd0);
    @(posedge clk_in); #1;
    bus.if_addr_in = 32'h100; bus.if_req_in = 1'b1;
    @(posedge clk_in);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("if_rd_addr", 64'(bus.mem_a), 64'(32'h100 + 32'(i)));
      chk("if_rd_nowr", 64'(bus.mem_wr), 64'd0);
    end
    @(negedge clk_in);
    chk("if_done_latency", 64'(bus.if_done_out), 64'd1);
    chk("if_word", 64'(bus.if_data_out), 64'h0000_0513);
    chk("if_mem_a_zero", 64'(bus.mem_a), 64'd0);
    #1 bus.if_req_in = 1'b0;

    // store word
    w0 = wr_cnt;
    model_access(1'b1, 1'b1, 2'd2, 32'h2000, 32'hDEAD_BEEF);
    lsb_go(1'b1, 2'd2, 32'h2000, 32'hDEAD_BEEF);
    chk("store_word_writes", 64'(wr_cnt - w0), 64'd4);

    // IO byte store held off by a full UART buffer for three cycles
    @(posedge clk_in); #1 bus.io_buffer_full = 1'b1;
    w0 = wr_cnt;
    model_access(1'b1, 1'b1, 2'd0, 32'h3_0000, 32'h41);
    fork
      lsb_go(1'b1, 2'd0, 32'h3_0000, 32'h41);
      begin
        repeat (4) @(posedge clk_in);
        #1 bus.io_buffer_full = 1'b0;
      end
    join
    chk("io_store_writes", 64'(wr_cnt - w0), 64'd1);

    // simultaneous LSB half load and IF read: LSB served first
    phys[12'h010] = 8'hF3; phys[12'h011] = 8'h9A;
    ref_mem[12'h010] = 8'hF3; ref_mem[12'h011] = 8'h9A;
    model_access(1'b1, 1'b0, 2'd1, 32'h10, 32'd0);
    model_access(1'b0, 1'b0, 2'd0, 32'h200, 32'd0);
    fork
      lsb_go(1'b0, 2'd1, 32'h10, 32'd0);
      if_go(32'h200);
    join
    chk("half_zero_ext", 64'(bus.lsb_rdata_out), 64'h0000_9AF3);

    // flush after two IF bytes, request stays high
    @(posedge clk_in); #1;
    start = if_done_cnt;
    bus.if_addr_in = 32'h300; bus.if_req_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 flush_in = 1'b1;
    @(posedge clk_in); #1 flush_in = 1'b0;
    model_access(1'b0, 1'b0, 2'd0, 32'h300, 32'd0);
    @(negedge clk_in);
    chk("flush_idle", 64'(busy_out), 64'd0);
    chk("flush_mem_a", 64'(bus.mem_a), 64'd0);
    @(negedge clk_in);
    chk("flush_reaccept", 64'(busy_out), 64'd1);
    chk("flush_no_done", 64'(if_done_cnt), 64'(start));
    wait_done(1'b0, start, "flush_if_timeout");
    bus.if_req_in = 1'b0;

    // half store with rdy_in low for two cycles after acceptance
    w0 = wr_cnt;
    model_access(1'b1, 1'b1, 2'd1, 32'h400, 32'h0000_A55A);
    fork
      lsb_go(1'b1, 2'd1, 32'h400, 32'h0000_A55A);
      begin
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 1'b1;
      end
    join
    chk("pause_store_writes", 64'(wr_cnt - w0), 64'd2);

    // address wrap
    model_access(1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'd0);
    if_go(32'hFFFF_FFFE);

    // randomized traffic with random pauses and UART back-pressure
    rand_en = 1'b1;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      case (kind)
        0: begin model_access(1'b0, 1'b0, 2'd0, a, 32'd0); if_go(a); end
        1: begin model_access(1'b1, 1'b0, sz, a, 32'd0); lsb_go(1'b0, sz, a, 32'd0); end
        2: begin model_access(1'b1, 1'b1, sz, a, wd); lsb_go(1'b1, sz, a, wd); end
        default: begin
          model_access(1'b1, kind[0] ^ wd[0], sz, a, wd);
          model_access(1'b0, 1'b0, 2'd0, a + 32'd1, 32'd0);
          fork
            lsb_go(kind[0] ^ wd[0], sz, a, wd);
            if_go(a + 32'd1);
          join
        end
      endcase
    end
    rand_en = 1'b0;
    @(posedge clk_in); #1;
    rdy_in = 1'b1; bus.io_buffer_full = 1'b0;
    repeat (3) @(posedge clk_in);

    // reset in the middle of a word store
    start = lsb_done_cnt;
    model_access(1'b1, 1'b1, 2'd2, 32'h2100, 32'hCAFE_F00D);
    @(posedge clk_in); #1;
    bus.lsb_wr_in = 1'b1; bus.lsb_size_in = 2'd2; bus.lsb_addr_in = 32'h2100;
    bus.lsb_wdata_in = 32'hCAFE_F00D; bus.lsb_req_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0; bus.lsb_req_in = 1'b0;
    @(posedge clk_in); #1;
    wr_q.delete(); lsb_q.delete(); ord_q.delete();
    @(negedge clk_in);
    chk("midrst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("midrst_mem_a", 64'(bus.mem_a), 64'd0);
    chk("midrst_busy", 64'(busy_out), 64'd0);
    @(posedge clk_in); #1 rst_in = 1'b1;
    repeat (6) @(negedge clk_in);
    chk("midrst_no_done", 64'(lsb_done_cnt), 64'(start));

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("done_queue_drained", 64'(ord_q.size()), 64'd0);
    chk("if_queue_drained", 64'(if_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
